// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_add_ctrl
// Description : Sequencer for a shared single-digit BCD adder. It adds two
//               DIGITS-wide packed-BCD operands one digit per cycle, LSD first,
//               chaining each digit's carry into the next.
//               Optional feature macro: BCD_CHECK_EN (operand digit check, err).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] in1,
  input  logic [4*DIGITS-1:0] in2,
  input  logic                carry_in,
  output logic [3:0]          add_in1,
  output logic [3:0]          add_in2,
  output logic                add_cin,
  input  logic [3:0]          add_sum,
  input  logic                add_cout,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry_out
`ifdef BCD_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int              IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] op_a_q, op_a_d;
  logic [4*DIGITS-1:0] op_b_q, op_b_d;
  logic [4*DIGITS-1:0] sum_q, sum_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic [IDXW+1:0]     digit_base;

  // Bit offset of the digit currently being processed (idx * 4).
  assign digit_base = {idx_q, 2'b00};

`ifdef BCD_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  // Flag any operand digit outside 0..9 on the raw inputs.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((in1[4*i +: 4] > 4'd9) || (in2[4*i +: 4] > 4'd9)) begin
        bad_digit = 1'b1;
      end
    end
  end
`endif

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef BCD_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: capture on start, one digit per ADD cycle, single DONE cycle.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef BCD_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = in1;
          op_b_d  = in2;
          carry_d = carry_in;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef BCD_CHECK_EN
          // A bad operand skips the addition entirely and reports via err.
          err_d   = bad_digit;
          state_d = bad_digit ? S_DONE : S_ADD;
`else
          state_d = S_ADD;
`endif
        end
      end
      S_ADD: begin
        sum_d[digit_base +: 4] = add_sum;
        carry_d                = add_cout;
        if (idx_q == C_LAST_IDX) begin
          // Last digit: keep idx in range and publish the decimal carry.
          cout_d  = add_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: adder drive only while adding, status decoded from state.
  always_comb begin
    add_in1   = 4'd0;
    add_in2   = 4'd0;
    add_cin   = 1'b0;
    if (state_q == S_ADD) begin
      add_in1 = op_a_q[digit_base +: 4];
      add_in2 = op_b_q[digit_base +: 4];
      add_cin = carry_q;
    end
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    sum       = sum_q;
    carry_out = cout_q;
`ifdef BCD_CHECK_EN
    err       = err_q;
`endif
  end

endmodule
`default_nettype wire
